// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select and the IF/ID pipeline register.
// Latency: the word at imem_addr reaches d_inst one clk edge later.
// Backpressure: stall holds the PC and IF/ID; flush redirects and inserts a bubble.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pcsrc,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] d_inst,
    output logic [31:0] d_pc4,
    output logic        d_valid,
    output logic [5:0]  d_op,
    output logic [4:0]  d_rs,
    output logic [4:0]  d_rt,
    output logic [4:0]  d_rd,
    output logic [5:0]  d_func,
    output logic [15:0] d_imm,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        SEL_PC4 = 2'b00,
        SEL_BPC = 2'b01,
        SEL_RPC = 2'b10,
        SEL_JPC = 2'b11
    } pcsel_t;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] redirect_pc;

    assign pc4       = pc + 32'd4;
    assign imem_addr = pc;

    // Redirect target; only consulted on flush, so pcsrc is a don't-care otherwise.
    always_comb begin
        redirect_pc = pc4;
        case (pcsel_t'(pcsrc))
            SEL_PC4: redirect_pc = pc4;
            SEL_BPC: redirect_pc = bpc;
            SEL_RPC: redirect_pc = rpc;
            SEL_JPC: redirect_pc = jpc;
            default: redirect_pc = pc4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= {RESET_PC[31:2], 2'b00};
            d_inst    <= NOP_INST;
            d_pc4     <= 32'd0;
            d_valid   <= 1'b0;
            fetch_cnt <= 32'd0;
        end else if (flush) begin
            pc        <= {redirect_pc[31:2], 2'b00};
            d_inst    <= NOP_INST;
            d_pc4     <= 32'd0;
            d_valid   <= 1'b0;
        end else if (!stall) begin
            pc        <= {pc4[31:2], 2'b00};
            d_inst    <= imem_data;
            d_pc4     <= pc4;
            d_valid   <= 1'b1;
            fetch_cnt <= fetch_cnt + 32'd1;
        end
    end

    assign d_op   = d_inst[31:26];
    assign d_rs   = d_inst[25:21];
    assign d_rt   = d_inst[20:16];
    assign d_rd   = d_inst[15:11];
    assign d_func = d_inst[5:0];
    assign d_imm  = d_inst[15:0];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, free-run, stall, flush variants, PC wrap, reset over redirect.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic [1:0]  pcsrc;
    logic [31:0] bpc, rpc, jpc;
    logic [31:0] imem_addr, imem_data;
    logic [31:0] d_inst, d_pc4, fetch_cnt;
    logic        d_valid;
    logic [5:0]  d_op, d_func;
    logic [4:0]  d_rs, d_rt, d_rd;
    logic [15:0] d_imm;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .pcsrc     (pcsrc),
        .bpc       (bpc),
        .rpc       (rpc),
        .jpc       (jpc),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .d_inst    (d_inst),
        .d_pc4     (d_pc4),
        .d_valid   (d_valid),
        .d_op      (d_op),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_rd      (d_rd),
        .d_func    (d_func),
        .d_imm     (d_imm),
        .fetch_cnt (fetch_cnt)
    );

    // Instruction memory: three fixed words, everything else a unique address-derived word.
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        if (a == 32'h0)      return 32'h2001_0005;
        else if (a == 32'h4) return 32'h0000_0000;
        else if (a == 32'h8) return 32'h0062_0820;
        else                 return 32'hAC00_0000 ^ a;
    endfunction

    assign imem_data = inst_at(imem_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_if(input string tag, input logic [31:0] addr, input logic [31:0] inst,
                          input logic [31:0] pc4, input logic vld, input logic [31:0] cnt);
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".inst"},  d_inst,    inst);
        chk({tag, ".pc4"},   d_pc4,     pc4);
        chk({tag, ".valid"}, {31'd0, d_valid}, {31'd0, vld});
        chk({tag, ".cnt"},   fetch_cnt, cnt);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; flush = 1'b0; pcsrc = 2'b00;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
        tick();
        chk_if("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);

        rst = 1'b0;
        tick();
        chk_if("run1", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd1);
        chk("run1.op",  {26'd0, d_op},   32'h08);
        chk("run1.rt",  {27'd0, d_rt},   32'h01);
        chk("run1.imm", {16'd0, d_imm},  32'h0005);
        tick();
        chk_if("run2", 32'h8, 32'h0000_0000, 32'h8, 1'b1, 32'd2);
        tick();
        chk_if("run3", 32'hC, 32'h0062_0820, 32'hC, 1'b1, 32'd3);
        chk("run3.op",   {26'd0, d_op},   32'h00);
        chk("run3.rs",   {27'd0, d_rs},   32'h03);
        chk("run3.rt",   {27'd0, d_rt},   32'h02);
        chk("run3.rd",   {27'd0, d_rd},   32'h01);
        chk("run3.func", {26'd0, d_func}, 32'h20);
        chk("run3.imm",  {16'd0, d_imm},  32'h0820);
        tick();
        chk_if("run4", 32'h10, 32'hAC00_000C, 32'h10, 1'b1, 32'd4);

        // Stall two cycles; pcsrc/jpc must be ignored without flush.
        stall = 1'b1; pcsrc = 2'b11; jpc = 32'h80;
        tick();
        chk_if("stall1", 32'h10, 32'hAC00_000C, 32'h10, 1'b1, 32'd4);
        tick();
        chk_if("stall2", 32'h10, 32'hAC00_000C, 32'h10, 1'b1, 32'd4);
        stall = 1'b0;
        tick();
        chk_if("resume", 32'h14, 32'hAC00_0010, 32'h14, 1'b1, 32'd5);
        pcsrc = 2'b00;
        tick();
        chk_if("run18", 32'h18, 32'hAC00_0014, 32'h18, 1'b1, 32'd6);

        flush = 1'b1; pcsrc = 2'b01; bpc = 32'h40;
        tick();
        chk_if("flush_bpc", 32'h40, 32'h0, 32'h0, 1'b0, 32'd6);
        flush = 1'b0;
        tick();
        chk_if("after_bpc", 32'h44, 32'hAC00_0040, 32'h44, 1'b1, 32'd7);

        flush = 1'b1; stall = 1'b1; pcsrc = 2'b10; rpc = 32'h0000_0103;
        tick();
        chk_if("flush_stall_rpc", 32'h100, 32'h0, 32'h0, 1'b0, 32'd7);

        stall = 1'b0; pcsrc = 2'b00;
        tick();
        chk_if("flush_pc4", 32'h104, 32'h0, 32'h0, 1'b0, 32'd7);

        pcsrc = 2'b11; jpc = 32'hFFFF_FFFF;
        tick();
        chk_if("flush_jpc", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'd7);
        flush = 1'b0;
        tick();
        chk_if("pc_wrap", 32'h0, 32'h53FF_FFFC, 32'h0, 1'b1, 32'd8);
        tick();
        chk_if("post_wrap", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd9);

        rst = 1'b1; flush = 1'b1; stall = 1'b1; pcsrc = 2'b11; jpc = 32'h80;
        tick();
        chk_if("rst_over_flush", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0; flush = 1'b0; stall = 1'b0; pcsrc = 2'b00;
        tick();
        chk_if("first_fetch", 32'h4, 32'h2001_0005, 32'h4, 1'b1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
